axis_burst_packer: RTL



---
 rtl/axis_burst_packer_if.sv | 25 ++
 rtl/axis_burst_packer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/axis_burst_packer_if.sv
// AXI-S bundle around the sample packer: narrow sample input and wide packed-word output.
// The master view belongs to the packer; the slave view belongs to the source and sink.
interface axis_burst_packer_if #(
  parameter int IN_WIDTH = 16,
  parameter int RATIO    = 4
);
  logic [IN_WIDTH-1:0]       s_rx_tdata;
  logic                      s_rx_tvalid;
  logic                      s_rx_tready;
  logic [IN_WIDTH*RATIO-1:0] m_tx_tdata;
  logic                      m_tx_tvalid;
  logic                      m_tx_tready;
  logic                      m_tx_tlast;
  logic [RATIO-1:0]          m_tx_tkeep;

  modport master (
    input  s_rx_tdata, s_rx_tvalid, m_tx_tready,
    output s_rx_tready, m_tx_tdata, m_tx_tvalid, m_tx_tlast, m_tx_tkeep
  );

  modport slave (
    output s_rx_tdata, s_rx_tvalid, m_tx_tready,
    input  s_rx_tready, m_tx_tdata, m_tx_tvalid, m_tx_tlast, m_tx_tkeep
  );
endinterface

// File: rtl/axis_burst_packer.sv
// Packs RATIO narrow samples into one wide word, frames words into bursts with tlast.
// The word is on m_tx one cycle after its last sample; input stalls only on a full stalled word or pending flush.
module axis_burst_packer #(
  parameter int IN_WIDTH   = 16,
  parameter int RATIO      = 4,
  parameter int OUT_WIDTH  = IN_WIDTH * RATIO,
  parameter int BURST_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BURST_BITS-1:0] cfg_burst_words,
  input  logic                  flush,
  axis_burst_packer_if.master   bus
);
  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CW = LW + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  typedef enum logic [0:0] {ST_RUN, ST_FLUSH_PEND} state_t;

  state_t                         state_q, state_d;
  logic [LW-1:0]                  lane_q, lane_d;
  logic [RATIO-1:0][IN_WIDTH-1:0] acc_q, acc_d;
  logic [BURST_BITS-1:0]          bcnt_q, bcnt_d;
  logic [BURST_BITS-1:0]          blim_q, blim_d;
  logic [OUT_WIDTH-1:0]           out_data_q, out_data_d;
  logic                           out_vld_q, out_vld_d;
  logic                           out_last_q, out_last_d;
  logic [RATIO-1:0]               out_keep_q, out_keep_d;

  logic                           rx_rdy;
  logic                           accept;
  logic                           load_ok;
  logic                           word_last;
  logic [CW-1:0]                  fill_cnt;
  logic [BURST_BITS-1:0]          lim_eff;
  logic [RATIO-1:0][IN_WIDTH-1:0] word;
  logic [RATIO-1:0]               word_keep;

  // Only the completing beat needs the output register, so earlier lanes keep flowing during a stall.
  assign rx_rdy    = !rst && (state_q == ST_RUN) &&
                     !((lane_q == LAST_LANE) && out_vld_q && !bus.m_tx_tready);
  assign accept    = bus.s_rx_tvalid && rx_rdy;
  assign load_ok   = !out_vld_q || bus.m_tx_tready;
  assign fill_cnt  = {1'b0, lane_q} + CW'(accept);
  assign lim_eff   = (bcnt_q == '0) ? cfg_burst_words : blim_q;
  assign word_last = (bcnt_q == lim_eff);

  // Word as it would leave this cycle: filled lanes (including this cycle's beat), rest zeroed.
  always_comb begin
    word      = '0;
    word_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CW'(i) < fill_cnt) begin
        word_keep[i] = 1'b1;
        word[i]      = (accept && (lane_q == LW'(i))) ? bus.s_rx_tdata : acc_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    acc_d      = acc_q;
    bcnt_d     = bcnt_q;
    blim_d     = blim_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_keep_d = out_keep_q;

    if (out_vld_q && bus.m_tx_tready) begin
      out_vld_d = 1'b0;
    end

    if (accept) begin
      acc_d[lane_q] = bus.s_rx_tdata;
      lane_d        = lane_q + 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (flush) begin
          if (fill_cnt != '0) begin
            if (load_ok) begin
              out_data_d = word;
              out_keep_d = word_keep;
              out_last_d = 1'b1;
              out_vld_d  = 1'b1;
              bcnt_d     = '0;
              lane_d     = '0;
            end else begin
              state_d = ST_FLUSH_PEND;
            end
          end else if (out_vld_q && !bus.m_tx_tready) begin
            // Nothing to pack: close the burst on the word already waiting.
            out_last_d = 1'b1;
            bcnt_d     = '0;
          end
        end else if (accept && (lane_q == LAST_LANE)) begin
          out_data_d = word;
          out_keep_d = word_keep;
          out_last_d = word_last;
          out_vld_d  = 1'b1;
          if (bcnt_q == '0) begin
            blim_d = cfg_burst_words;
          end
          bcnt_d = word_last ? '0 : bcnt_q + 1'b1;
        end
      end
      ST_FLUSH_PEND: begin
        if (load_ok) begin
          out_data_d = word;
          out_keep_d = word_keep;
          out_last_d = 1'b1;
          out_vld_d  = 1'b1;
          bcnt_d     = '0;
          lane_d     = '0;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      lane_q     <= '0;
      acc_q      <= '0;
      bcnt_q     <= '0;
      blim_q     <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_keep_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      bcnt_q     <= bcnt_d;
      blim_q     <= blim_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_keep_q <= out_keep_d;
    end
  end

  assign bus.s_rx_tready = rx_rdy;
  assign bus.m_tx_tdata  = out_data_q;
  assign bus.m_tx_tvalid = out_vld_q;
  assign bus.m_tx_tlast  = out_last_q;
  assign bus.m_tx_tkeep  = out_keep_q;
endmodule
